food_spawner: RTL and testbench
===============================

FOOD_SPAWNER -- requirements
Module: food_spawner

Interface
REQ-001 The block SHALL have parameter GRID_W, default 40, playfield width in cells (1..64).
REQ-002 The block SHALL have parameter GRID_H, default 30, playfield height in cells (1..64).
REQ-003 The block SHALL have parameter MAX_TRIES, default 16, random attempts before fallback scan (1..255).
REQ-004 The block SHALL have port clk1  input  1  system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port spawn_req  input  1  request a new food position; sampled only in IDLE.
REQ-007 The block SHALL have ports rnd_x / rnd_y  input  6 each  pseudo-random coordinates from the coordinate generator, assumed free-running.
REQ-008 The block SHALL have ports occ_rd  output  1  and occ_x / occ_y  output  6 each  snake-occupancy query strobe and cell address.
REQ-009 The block SHALL have port occ_hit  input  1  occupancy result, valid exactly one cycle after occ_rd; 1 = cell holds snake.
REQ-010 The block SHALL have ports food_x / food_y  output  6 each  current food cell.
REQ-011 The block SHALL have port food_valid  output  1  food_x/food_y hold a verified free cell.
REQ-012 The block SHALL have ports spawn_done and spawn_fail  output  1 each  single-cycle completion pulses.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, SAMPLE, QUERY, CHECK, SCAN_Q, SCAN_C, DONE, FAIL.
REQ-015 IDLE with spawn_req=1 SHALL go to SAMPLE, clear food_valid, and clear the try counter; spawn_req while busy SHALL be ignored (not queued).
REQ-016 SAMPLE SHALL register (rnd_x, rnd_y) as candidate; if rnd_x<GRID_W and rnd_y<GRID_H go to QUERY, else increment try counter and stay in SAMPLE.
REQ-017 QUERY SHALL drive occ_rd=1 with occ_x/occ_y=candidate for exactly one cycle, then go to CHECK.
REQ-018 CHECK SHALL sample occ_hit: 0 -> load food_x/food_y with candidate, go to DONE; 1 -> increment try counter, go to SAMPLE.
REQ-019 When the try counter reaches MAX_TRIES (out-of-range or occupied attempts both count), the FSM SHALL enter SCAN_Q with scan cell (0,0) instead of SAMPLE.
REQ-020 SCAN_Q/SCAN_C SHALL query each cell in row-major order (x fastest, x wraps at GRID_W-1 to 0 with y+1), two cycles per cell; the first free cell SHALL be loaded into food_x/food_y, then go to DONE.
REQ-021 If cell (GRID_W-1, GRID_H-1) is found occupied in scan, the FSM SHALL go to FAIL; food_valid SHALL remain 0 and food_x/food_y SHALL keep their old values.
REQ-022 DONE SHALL assert spawn_done=1 and food_valid=1 for one cycle and return to IDLE; food_valid SHALL stay 1 until the next accepted spawn_req.
REQ-023 FAIL SHALL assert spawn_fail=1 for one cycle and return to IDLE.
REQ-024 Best-case latency: spawn_req in cycle 0 -> SAMPLE cycle 1, occ_rd cycle 2, CHECK cycle 3, spawn_done and food_valid high cycle 4.
REQ-025 occ_rd SHALL be 0 outside QUERY and SCAN_Q; occ_x/occ_y are don't-care when occ_rd=0.
REQ-026 All outputs SHALL be registered; try counter SHALL be 8 bits, saturating; no output glitches between states.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, food_x=0, food_y=0, food_valid=0, spawn_done=0, spawn_fail=0, occ_rd=0, busy=0, try counter=0, scan cell=(0,0).
REQ-028 Reset asserted mid-search SHALL abandon the search with no spawn_done or spawn_fail pulse after release.

Verification
REQ-029 rnd=(5,7), occ_hit=0, spawn_req cycle 0 -> occ_rd cycle 2 at (5,7), spawn_done cycle 4, food=(5,7), food_valid=1.
REQ-030 rnd=(50,3) for 3 samples then (10,10), occ_hit=0 -> occ_rd only for (10,10), spawn_done cycle 7, food=(10,10).
REQ-031 occ_hit=1 for all random queries, cells (0,0),(1,0) occupied, (2,0) free -> after 16 tries scan; food=(2,0), spawn_done once.
REQ-032 occ_hit tied 1, GRID_W=4, GRID_H=2 -> 8 scan queries after tries, spawn_fail pulse, food_valid=0, food unchanged.
REQ-033 spawn_req pulsed while busy -> no extra spawn_done; rst_n low during SCAN_C -> all outputs zero, no pulse after release.

Source files
------------

// File: rtl/food_spawner.sv
// Food placement engine: draws random candidate cells, verifies them against snake
// occupancy, and falls back to a row-major scan after MAX_TRIES failed attempts.
module food_spawner #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int MAX_TRIES = 16
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic       spawn_req,
    input  logic [5:0] rnd_x,
    input  logic [5:0] rnd_y,
    output logic       occ_rd,
    output logic [5:0] occ_x,
    output logic [5:0] occ_y,
    input  logic       occ_hit,
    output logic [5:0] food_x,
    output logic [5:0] food_y,
    output logic       food_valid,
    output logic       spawn_done,
    output logic       spawn_fail,
    output logic       busy
);

    localparam logic [6:0] GW    = 7'(GRID_W);
    localparam logic [6:0] GH    = 7'(GRID_H);
    localparam logic [5:0] XMAX  = 6'(GRID_W - 1);
    localparam logic [5:0] YMAX  = 6'(GRID_H - 1);
    localparam logic [7:0] MAX_T = 8'(MAX_TRIES);

    typedef enum logic [2:0] {IDLE, SAMPLE, QUERY, CHECK, SCAN_Q, SCAN_C, DONE, FAIL} state_t;

    state_t     state, nxt;
    logic [7:0] try_cnt, try_inc;
    logic [5:0] cand_x, cand_y, scan_x, scan_y, scan_x_d, scan_y_d;
    logic [5:0] occ_x_d, occ_y_d, food_x_d, food_y_d;
    logic       occ_rd_d, food_valid_d, spawn_done_d, spawn_fail_d, busy_d;
    logic       rnd_ok, tries_out, last_cell;

    assign try_inc   = (try_cnt == 8'hFF) ? try_cnt : try_cnt + 8'd1;
    assign tries_out = (try_inc >= MAX_T);
    assign rnd_ok    = ({1'b0, rnd_x} < GW) && ({1'b0, rnd_y} < GH);
    assign last_cell = (scan_x == XMAX) && (scan_y == YMAX);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next state, plus the scan cursor so the query address can be registered with it.
    always_comb begin
        nxt      = state;
        scan_x_d = scan_x;
        scan_y_d = scan_y;
        case (state)
            IDLE:   if (spawn_req) nxt = SAMPLE;
            SAMPLE: begin
                if (rnd_ok) nxt = QUERY;
                else if (tries_out) begin
                    nxt = SCAN_Q; scan_x_d = '0; scan_y_d = '0;
                end
            end
            QUERY:  nxt = CHECK;
            CHECK: begin
                if (!occ_hit) nxt = DONE;
                else if (tries_out) begin
                    nxt = SCAN_Q; scan_x_d = '0; scan_y_d = '0;
                end else nxt = SAMPLE;
            end
            SCAN_Q: nxt = SCAN_C;
            SCAN_C: begin
                if (!occ_hit) nxt = DONE;
                else if (last_cell) nxt = FAIL;
                else begin
                    nxt = SCAN_Q;
                    if (scan_x == XMAX) begin
                        scan_x_d = '0;
                        scan_y_d = scan_y + 6'd1;
                    end else scan_x_d = scan_x + 6'd1;
                end
            end
            DONE:    nxt = IDLE;
            FAIL:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered, so they change only on edges.
    always_comb begin
        busy_d       = (nxt != IDLE);
        occ_rd_d     = (nxt == QUERY) || (nxt == SCAN_Q);
        occ_x_d      = (nxt == QUERY) ? rnd_x : scan_x_d;
        occ_y_d      = (nxt == QUERY) ? rnd_y : scan_y_d;
        spawn_done_d = (nxt == DONE);
        spawn_fail_d = (nxt == FAIL);
        food_x_d     = food_x;
        food_y_d     = food_y;
        food_valid_d = food_valid;
        if (state == IDLE && spawn_req) food_valid_d = 1'b0;
        if (nxt == DONE) food_valid_d = 1'b1;
        if (state == CHECK && !occ_hit) begin
            food_x_d = cand_x; food_y_d = cand_y;
        end
        if (state == SCAN_C && !occ_hit) begin
            food_x_d = scan_x; food_y_d = scan_y;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            occ_rd     <= 1'b0;
            occ_x      <= '0;
            occ_y      <= '0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            spawn_done <= 1'b0;
            spawn_fail <= 1'b0;
            busy       <= 1'b0;
        end else begin
            occ_rd     <= occ_rd_d;
            occ_x      <= occ_x_d;
            occ_y      <= occ_y_d;
            food_x     <= food_x_d;
            food_y     <= food_y_d;
            food_valid <= food_valid_d;
            spawn_done <= spawn_done_d;
            spawn_fail <= spawn_fail_d;
            busy       <= busy_d;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            try_cnt <= '0;
            cand_x  <= '0;
            cand_y  <= '0;
            scan_x  <= '0;
            scan_y  <= '0;
        end else begin
            scan_x <= scan_x_d;
            scan_y <= scan_y_d;
            if (state == IDLE && spawn_req) try_cnt <= '0;
            if (state == SAMPLE) begin
                cand_x <= rnd_x;
                cand_y <= rnd_y;
                if (!rnd_ok) try_cnt <= try_inc;
            end
            if (state == CHECK && occ_hit) try_cnt <= try_inc;
        end
    end

endmodule

// File: tb/tb_food_spawner.sv
// Bench for food_spawner: occupancy responder, per-cycle monitor and an attempt-level
// reference model of the random/scan search; a second small-grid instance covers FAIL.
module tb_food_spawner;
    localparam int W = 40, H = 30, MT = 16;

    logic       clk1 = 1'b0, rst_n = 1'b0, spawn_req = 1'b0, occ_hit = 1'b0;
    logic [5:0] rnd_x = '0, rnd_y = '0;
    logic       occ_rd, food_valid, spawn_done, spawn_fail, busy;
    logic [5:0] occ_x, occ_y, food_x, food_y;

    logic       s_req = 1'b0, s_hit = 1'b0;
    logic       s_occ_rd, s_fv, s_done, s_fail, s_busy;
    logic [5:0] s_occ_x, s_occ_y, s_food_x, s_food_y;

    int  n_pass = 0, n_total = 0;
    int  cyc = 0, start_cyc = 0;
    bit  rec_en = 1'b0, rec_s = 1'b0, pend = 1'b0;
    bit  occ_map [0:63][0:63];
    int  tab_x[$], tab_y[$];
    int  oq_x[$], oq_y[$], oq_c[$], done_q[$], fail_q[$], fv_q[$], busy_q[$];
    int  sq_x[$], sq_y[$];
    int  s_done_n = 0, s_fail_n = 0;

    food_spawner #(.GRID_W(W), .GRID_H(H), .MAX_TRIES(MT)) dut (
        .clk1(clk1), .rst_n(rst_n), .spawn_req(spawn_req), .rnd_x(rnd_x), .rnd_y(rnd_y),
        .occ_rd(occ_rd), .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .spawn_done(spawn_done), .spawn_fail(spawn_fail), .busy(busy));

    food_spawner #(.GRID_W(4), .GRID_H(2), .MAX_TRIES(4)) dut_small (
        .clk1(clk1), .rst_n(rst_n), .spawn_req(s_req), .rnd_x(rnd_x), .rnd_y(rnd_y),
        .occ_rd(s_occ_rd), .occ_x(s_occ_x), .occ_y(s_occ_y), .occ_hit(s_hit),
        .food_x(s_food_x), .food_y(s_food_y), .food_valid(s_fv),
        .spawn_done(s_done), .spawn_fail(s_fail), .busy(s_busy));

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    // Occupancy memory: answer arrives in the cycle after the query strobe.
    always @(posedge clk1) begin
        #1;
        occ_hit = pend;
        pend = (occ_rd === 1'b1) ? occ_map[occ_x][occ_y] : 1'b0;
    end

    always @(negedge clk1) begin
        if (rec_en) begin
            if (occ_rd === 1'b1) begin
                oq_x.push_back(int'(occ_x)); oq_y.push_back(int'(occ_y));
                oq_c.push_back(cyc - start_cyc);
            end
            if (spawn_done === 1'b1) done_q.push_back(cyc - start_cyc);
            if (spawn_fail === 1'b1) fail_q.push_back(cyc - start_cyc);
            fv_q.push_back(int'(food_valid));
            busy_q.push_back(int'(busy));
        end
        if (rec_s) begin
            if (s_occ_rd === 1'b1) begin
                sq_x.push_back(int'(s_occ_x)); sq_y.push_back(int'(s_occ_y));
            end
            if (s_done === 1'b1) s_done_n++;
            if (s_fail === 1'b1) s_fail_n++;
        end
    end

    task automatic clear_map();
        for (int x = 0; x < 64; x++) for (int y = 0; y < 64; y++) occ_map[x][y] = 1'b0;
    endtask

    // One spawn request against the main instance, checked against an attempt-level model
    // driven by the per-cycle rnd table (tab[k] is what the block sees in relative cycle k).
    task automatic run_spawn(input string name, input int budget, input bit busy_pulses);
        int t, tries, exp_done, exp_fail, ef_x, ef_y, end_rel, ok;
        int ex[$], ey[$], ec[$];
        logic [5:0] old_x, old_y;
        t = 1; tries = 0; exp_done = -1; exp_fail = -1; ef_x = 0; ef_y = 0;
        while (exp_done < 0 && exp_fail < 0 && t < tab_x.size()) begin
            if (tab_x[t] < W && tab_y[t] < H) begin
                ex.push_back(tab_x[t]); ey.push_back(tab_y[t]); ec.push_back(t + 1);
                if (!occ_map[tab_x[t]][tab_y[t]]) begin
                    ef_x = tab_x[t]; ef_y = tab_y[t]; exp_done = t + 3;
                end else begin tries++; t += 3; end
            end else begin tries++; t++; end
            if (exp_done < 0 && tries >= MT) begin
                for (int i = 0; i < W * H; i++) begin
                    ex.push_back(i % W); ey.push_back(i / W); ec.push_back(t + 2 * i);
                    if (!occ_map[i % W][i / W]) begin
                        ef_x = i % W; ef_y = i / W; exp_done = t + 2 * i + 2; break;
                    end
                end
                if (exp_done < 0) exp_fail = t + 2 * W * H;
            end
        end
        end_rel = (exp_done >= 0) ? exp_done + 3 : (exp_fail >= 0 ? exp_fail + 3 : budget);
        if (end_rel > budget) end_rel = budget;
        old_x = food_x; old_y = food_y;
        oq_x.delete(); oq_y.delete(); oq_c.delete(); done_q.delete(); fail_q.delete();
        fv_q.delete(); busy_q.delete();
        @(posedge clk1); #1;
        start_cyc = cyc; rec_en = 1'b1; spawn_req = 1'b1;
        rnd_x = 6'(tab_x[0]); rnd_y = 6'(tab_y[0]);
        for (int i = 1; i <= end_rel; i++) begin
            @(posedge clk1); #1;
            spawn_req = busy_pulses && i >= 2 && i <= 4;
            rnd_x = (i < tab_x.size()) ? 6'(tab_x[i]) : 6'd63;
            rnd_y = (i < tab_y.size()) ? 6'(tab_y[i]) : 6'd63;
        end
        @(negedge clk1); #1; rec_en = 1'b0;

        n_total++;
        if (exp_done < 0 && exp_fail < 0) $display("FAIL %s model: search did not finish within budget %0d", name, budget);
        else n_pass++;
        n_total++;
        if (done_q.size() != (exp_done >= 0 ? 1 : 0) || (exp_done >= 0 && done_q.size() == 1 && done_q[0] != exp_done))
            $display("FAIL %s done: got %0d pulses (first at %0d), want done at %0d", name, done_q.size(),
                     done_q.size() > 0 ? done_q[0] : -1, exp_done);
        else n_pass++;
        n_total++;
        if (fail_q.size() != (exp_fail >= 0 ? 1 : 0))
            $display("FAIL %s fail_pulse: got %0d pulses, want %0d", name, fail_q.size(), exp_fail >= 0 ? 1 : 0);
        else n_pass++;
        ok = (oq_x.size() == ex.size());
        for (int i = 0; ok && i < ex.size(); i++)
            if (oq_x[i] != ex[i] || oq_y[i] != ey[i] || oq_c[i] != ec[i]) begin
                ok = 0;
                $display("FAIL %s query[%0d]: got (%0d,%0d)@%0d want (%0d,%0d)@%0d", name, i,
                         oq_x[i], oq_y[i], oq_c[i], ex[i], ey[i], ec[i]);
            end
        n_total++;
        if (ok) n_pass++;
        else if (oq_x.size() != ex.size()) $display("FAIL %s query_count: got %0d want %0d", name, oq_x.size(), ex.size());
        n_total++;
        if (fv_q.size() < 2 || fv_q[1] != 0 || busy_q[1] != 1)
            $display("FAIL %s cycle1: food_valid=%0d busy=%0d want 0/1", name, fv_q.size() > 1 ? fv_q[1] : -1,
                     busy_q.size() > 1 ? busy_q[1] : -1);
        else n_pass++;
        n_total++;
        if (exp_done >= 0) begin
            if (food_valid !== 1'b1 || int'(food_x) != ef_x || int'(food_y) != ef_y || busy !== 1'b0)
                $display("FAIL %s food: got (%0d,%0d) v=%b busy=%b want (%0d,%0d) v=1 busy=0", name,
                         food_x, food_y, food_valid, busy, ef_x, ef_y);
            else n_pass++;
        end else begin
            if (food_valid !== 1'b0 || food_x !== old_x || food_y !== old_y)
                $display("FAIL %s food_kept: got (%0d,%0d) v=%b want (%0d,%0d) v=0", name,
                         food_x, food_y, food_valid, old_x, old_y);
            else n_pass++;
        end
    endtask

    task automatic fill_const(input int n, input int x, input int y);
        tab_x.delete(); tab_y.delete();
        for (int i = 0; i < n; i++) begin tab_x.push_back(x); tab_y.push_back(y); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk1);
        #1;
        n_total++;
        if ({occ_rd, food_x, food_y, food_valid, spawn_done, spawn_fail, busy} !== '0)
            $display("FAIL reset_state: got occ_rd=%b food=(%0d,%0d) v=%b done=%b fail=%b busy=%b want all 0",
                     occ_rd, food_x, food_y, food_valid, spawn_done, spawn_fail, busy);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(posedge clk1);
    endtask

    task automatic test_first_try();
        clear_map();
        fill_const(20, 5, 7);
        run_spawn("first_try", 20, 1'b0);
    endtask

    task automatic test_out_of_range();
        clear_map();
        fill_const(30, 10, 10);
        for (int i = 1; i <= 3; i++) begin tab_x[i] = 50; tab_y[i] = 3; end
        run_spawn("out_of_range", 30, 1'b0);
    endtask

    task automatic test_scan_fallback();
        int px[$], py[$], k;
        clear_map();
        occ_map[0][0] = 1'b1; occ_map[1][0] = 1'b1;
        px = '{0, 1}; py = '{0, 0};
        for (int i = 0; i < 6; i++) begin
            k = $urandom_range(3, 38); occ_map[k][i + 1] = 1'b1; px.push_back(k); py.push_back(i + 1);
        end
        tab_x.delete(); tab_y.delete();
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                k = $urandom_range(0, px.size() - 1); tab_x.push_back(px[k]); tab_y.push_back(py[k]);
            end else begin
                tab_x.push_back($urandom_range(40, 63)); tab_y.push_back($urandom_range(0, 63));
            end
        end
        run_spawn("scan_fallback", 120, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            clear_map();
            for (int x = 0; x < W; x++) for (int y = 0; y < H; y++) occ_map[x][y] = ($urandom_range(0, 3) == 0);
            tab_x.delete(); tab_y.delete();
            for (int i = 0; i < 400; i++) begin
                tab_x.push_back($urandom_range(0, 63)); tab_y.push_back($urandom_range(0, 63));
            end
            run_spawn($sformatf("random%0d", r), 400, r[0]);
        end
    endtask

    task automatic test_back_to_back();
        clear_map();
        occ_map[5][7] = 1'b1;
        fill_const(60, 9, 2);
        tab_x[1] = 5; tab_y[1] = 7;
        run_spawn("busy_req_ignored", 60, 1'b1);
        fill_const(20, 3, 4);
        run_spawn("back_to_back", 20, 1'b0);
    endtask

    task automatic test_small_fail();
        sq_x.delete(); sq_y.delete(); s_done_n = 0; s_fail_n = 0;
        @(posedge clk1); #1;
        rec_s = 1'b1; s_hit = 1'b0; rnd_x = 6'd3; rnd_y = 6'd1; s_req = 1'b1;
        @(posedge clk1); #1; s_req = 1'b0;
        repeat (8) @(posedge clk1);
        #1;
        n_total++;
        if (s_done_n != 1 || s_fv !== 1'b1 || s_food_x !== 6'd3 || s_food_y !== 6'd1)
            $display("FAIL small_free: done=%0d v=%b food=(%0d,%0d) want 1 1 (3,1)", s_done_n, s_fv, s_food_x, s_food_y);
        else n_pass++;
        sq_x.delete(); sq_y.delete(); s_done_n = 0;
        s_hit = 1'b1; rnd_x = 6'd9; rnd_y = 6'd9; s_req = 1'b1;
        @(posedge clk1); #1; s_req = 1'b0;
        repeat (30) @(posedge clk1);
        #1; rec_s = 1'b0;
        n_total++;
        if (s_fail_n != 1 || s_done_n != 0)
            $display("FAIL small_pulses: fail=%0d done=%0d want 1 0", s_fail_n, s_done_n);
        else n_pass++;
        n_total++;
        if (sq_x.size() != 8) $display("FAIL small_scan_count: got %0d want 8", sq_x.size());
        else begin
            int bad = 0;
            for (int i = 0; i < 8; i++)
                if (sq_x[i] != i % 4 || sq_y[i] != i / 4) bad++;
            if (bad != 0) $display("FAIL small_scan_order: got %0d out-of-order cells want 0", bad);
            else n_pass++;
        end
        n_total++;
        if (s_fv !== 1'b0 || s_food_x !== 6'd3 || s_food_y !== 6'd1 || s_busy !== 1'b0)
            $display("FAIL small_food_kept: v=%b food=(%0d,%0d) busy=%b want 0 (3,1) 0", s_fv, s_food_x, s_food_y, s_busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        clear_map();
        occ_map[0][0] = 1'b1; occ_map[1][0] = 1'b1;
        done_q.delete(); fail_q.delete();
        @(posedge clk1); #1;
        start_cyc = cyc; rec_en = 1'b1; spawn_req = 1'b1; rnd_x = 6'd50; rnd_y = 6'd50;
        @(posedge clk1); #1; spawn_req = 1'b0;
        repeat (17) @(posedge clk1);
        #1;
        n_total++;
        if (busy !== 1'b1 || occ_rd !== 1'b0) $display("FAIL mid_scan_busy: busy=%b occ_rd=%b want 1 0", busy, occ_rd);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({occ_rd, occ_x, occ_y, food_x, food_y, food_valid, spawn_done, spawn_fail, busy} !== '0)
            $display("FAIL reset_mid_scan: got occ_rd=%b food=(%0d,%0d) v=%b busy=%b want all 0",
                     occ_rd, food_x, food_y, food_valid, busy);
        else n_pass++;
        repeat (2) @(posedge clk1);
        #1; rst_n = 1'b1;
        repeat (12) @(posedge clk1);
        #1; rec_en = 1'b0;
        n_total++;
        if (done_q.size() != 0 || fail_q.size() != 0 || busy !== 1'b0)
            $display("FAIL post_reset_pulse: done=%0d fail=%0d busy=%b want 0 0 0", done_q.size(), fail_q.size(), busy);
        else n_pass++;
    endtask

    initial begin
        clear_map();
        test_reset();
        test_first_try();
        test_out_of_range();
        test_scan_fallback();
        test_back_to_back();
        test_random();
        test_small_fail();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
